frame_line_cmd_gen: RTL and testbench
=====================================

# frame_line_cmd_gen

Write-side command generator for the frame-buffer path. It sits directly downstream of the four-buffer mutex manager. On each write start-of-frame it captures the buffer base address the manager hands out. It then issues one memory-write command per image line (address, byte count, last flag) over a valid/ready handshake to the stream-to-memory mover.

## Interface
- C_ADDR_WIDTH, 32, width of frame_addr / cmd_addr / stride
- C_IMG_WBITS, 12, width of img_width
- C_IMG_HBITS, 12, width of img_height
- C_PIXEL_BYTES, 4, bytes per pixel; power of two, 1..8
- C_DROP_BITS, 8, width of drop_cnt
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- sof  in  1  write start-of-frame pulse, same pulse that drives the manager's w_sof
- frame_addr  in  C_ADDR_WIDTH  buffer base from manager (w_addr); valid one cycle after sof
- img_width  in  C_IMG_WBITS  pixels per line
- img_height  in  C_IMG_HBITS  lines per frame
- stride  in  C_ADDR_WIDTH  byte distance between line starts
- cmd_valid  out  1  command valid
- cmd_ready  in  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  out  C_ADDR_WIDTH  line start byte address
- cmd_bytes  out  C_IMG_WBITS+4  line length in bytes = img_width*C_PIXEL_BYTES
- cmd_last  out  1  high on the command for the last line of the frame
- busy  out  1  high while a frame is being issued
- frame_done  out  1  one-cycle pulse after the last command handshake
- drop_cnt  out  C_DROP_BITS  saturating count of discarded pending frames

## Operation
- Capture pipeline: sof is registered once (sof_d). On sof_d, frame_addr, img_width, img_height and stride are latched into a "next frame" slot and pend is set. Geometry inputs are quasi-static and only sampled there.
- States: IDLE, ISSUE.
- IDLE: if pend is set, load the slot into the working registers, clear pend and go to ISSUE. Working load: base = slot addr, line = 0, cmd_addr = base, cmd_bytes = width*C_PIXEL_BYTES, last_line = height-1.
  - If the loaded height==0 or width==0, emit no command. Pulse frame_done next cycle and stay IDLE.
- ISSUE: cmd_valid=1, busy=1.
  - On handshake: line += 1 and cmd_addr += stride (mod 2^C_ADDR_WIDTH).
  - On a handshake with line==last_line: drop cmd_valid and busy the next cycle, go to IDLE, and pulse frame_done that same cycle.
- cmd_last = (line==last_line) while cmd_valid.
- cmd_addr, cmd_bytes and cmd_last are held stable while cmd_valid & !cmd_ready. cmd_valid never drops without a handshake.
- sof arriving during ISSUE does not disturb the current frame. It fills the slot (pend=1). The slot starts as soon as the current frame ends.
- sof_d while pend is already 1: the slot is overwritten (latest frame wins) and drop_cnt += 1, saturating at all-ones.
- sof_d in the same cycle that IDLE consumes pend: the consume happens first, then the new capture sets pend again. No drop.
- Multiplication cmd_bytes = img_width << log2(C_PIXEL_BYTES); no overflow at the parameter limits.

## Timing
- Reset (resetn=0 at posedge): state=IDLE, pend=0, sof_d=0.
  - Outputs: cmd_valid=0, cmd_addr=0, cmd_bytes=0, cmd_last=0, busy=0, frame_done=0, drop_cnt=0.
  - Reset mid-frame abandons the frame; no frame_done.
- Latency sof -> first cmd_valid: 3 cycles from idle (sof_d, slot latch, IDLE->ISSUE load).
- Throughput: one command per cycle with cmd_ready held high.
- Frame to back-to-back pending frame: one IDLE cycle between the last handshake and the next cmd_valid.
- frame_done is exactly one cycle wide and aligned with the first cycle cmd_valid=0 after the last handshake.

## Test plan
- Basic frame: C_PIXEL_BYTES=4, frame_addr=0x3FF00000, width=5, height=3, stride=0x1000, cmd_ready=1, single sof.
  - Required: three commands at 0x3FF00000, 0x3FF01000, 0x3FF02000, each cmd_bytes=20.
  - cmd_last only on the third command; first cmd_valid 3 cycles after sof; one frame_done.
- Backpressure: same frame with cmd_ready random (50%).
  - Required: identical command sequence; fields stable while stalled; no duplicate or lost command.
- Pending and drop: height=40; sof at t0, then sofs at t0+10 (addr 0x3FF10000) and t0+20 (addr 0x3FF20000).
  - Required: frame 0x3FF00000 completes fully, then frame 0x3FF20000 is issued; 0x3FF10000 is never issued; drop_cnt=1.
- Degenerate geometry: sof with height=0, width=5.
  - Required: no cmd_valid; frame_done pulses once; busy stays 0.
- Wrap-around: frame_addr=0xFFFFF000, stride=0x1000, height=2.
  - Required: cmd_addr 0xFFFFF000 then 0x00000000.
- Reset mid-frame: resetn low during ISSUE after 2 of 6 handshakes.
  - Required: all outputs at reset values next cycle, pend cleared, no frame_done.
  - A new sof afterwards starts again at line 0.

Source files
------------

// File: rtl/frame_line_cmd_gen.sv
// Write-side line command generator: captures a buffer base on sof
// and issues one memory-write command per image line.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   sof                write start-of-frame pulse
//   frame_addr         buffer base, valid one cycle after sof
//   img_width          pixels per line
//   img_height         lines per frame
//   stride             byte distance between line starts
//   cmd_valid/ready    command handshake
//   cmd_addr           line start byte address
//   cmd_bytes          line length in bytes
//   cmd_last           last line of the frame
//   busy               frame being issued
//   frame_done         one-cycle pulse after last handshake
//   drop_cnt           saturating count of overwritten pending frames
module frame_line_cmd_gen #(
  parameter int C_ADDR_WIDTH  = 32,
  parameter int C_IMG_WBITS   = 12,
  parameter int C_IMG_HBITS   = 12,
  parameter int C_PIXEL_BYTES = 4,
  parameter int C_DROP_BITS   = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    sof,
  input  logic [C_ADDR_WIDTH-1:0] frame_addr,
  input  logic [C_IMG_WBITS-1:0]  img_width,
  input  logic [C_IMG_HBITS-1:0]  img_height,
  input  logic [C_ADDR_WIDTH-1:0] stride,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [C_ADDR_WIDTH-1:0] cmd_addr,
  output logic [C_IMG_WBITS+3:0]  cmd_bytes,
  output logic                    cmd_last,
  output logic                    busy,
  output logic                    frame_done,
  output logic [C_DROP_BITS-1:0]  drop_cnt
);

  localparam int SH = $clog2(C_PIXEL_BYTES);

  localparam logic [C_IMG_HBITS-1:0] H_ONE = 1;
  localparam logic [C_DROP_BITS-1:0] D_ONE = 1;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic sof_d;
  logic pend_q;

  logic [C_ADDR_WIDTH-1:0] slot_addr;
  logic [C_IMG_WBITS-1:0]  slot_w;
  logic [C_IMG_HBITS-1:0]  slot_h;
  logic [C_ADDR_WIDTH-1:0] slot_stride;

  logic [C_ADDR_WIDTH-1:0] stride_q;
  logic [C_IMG_HBITS-1:0]  line_q;
  logic [C_IMG_HBITS-1:0]  last_q;

  logic load;
  logic empty;
  logic hs;
  logic fin;
  logic at_last;

  assign at_last = (line_q == last_q);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    empty   = 1'b0;
    hs      = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          load = 1'b1;
          if (slot_w == '0 || slot_h == '0) begin
            empty = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        hs = cmd_ready;
        if (cmd_ready && at_last) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign cmd_valid = (state_q == ISSUE);
  assign busy      = (state_q == ISSUE);
  assign cmd_last  = cmd_valid && at_last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sof_d       <= 1'b0;
      pend_q      <= 1'b0;
      slot_addr   <= '0;
      slot_w      <= '0;
      slot_h      <= '0;
      slot_stride <= '0;
      stride_q    <= '0;
      line_q      <= '0;
      last_q      <= '0;
      cmd_addr    <= '0;
      cmd_bytes   <= '0;
      frame_done  <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      sof_d      <= sof;
      frame_done <= fin | empty;

      // A capture in the consume cycle refills the slot; only an
      // unconsumed slot being overwritten counts as a drop.
      if (sof_d) begin
        slot_addr   <= frame_addr;
        slot_w      <= img_width;
        slot_h      <= img_height;
        slot_stride <= stride;
        pend_q      <= 1'b1;
        if (pend_q && !load && drop_cnt != '1) begin
          drop_cnt <= drop_cnt + D_ONE;
        end
      end else if (load) begin
        pend_q <= 1'b0;
      end

      if (load) begin
        stride_q  <= slot_stride;
        line_q    <= '0;
        last_q    <= slot_h - H_ONE;
        cmd_addr  <= slot_addr;
        cmd_bytes <= {4'b0000, slot_w} << SH;
      end else if (hs) begin
        line_q   <= line_q + H_ONE;
        cmd_addr <= cmd_addr + stride_q;
      end
    end
  end

endmodule

// File: tb/tb_frame_line_cmd_gen.sv
// Self-checking bench for frame_line_cmd_gen: directed steps with a
// command scoreboard checked by a negedge monitor.
module tb_frame_line_cmd_gen;

  logic        clk;
  logic        resetn;
  logic        sof;
  logic [31:0] frame_addr;
  logic [11:0] img_width;
  logic [11:0] img_height;
  logic [31:0] stride;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_bytes;
  logic        cmd_last;
  logic        busy;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  typedef struct packed {
    logic [31:0] a;
    logic [15:0] b;
    logic        l;
  } cmd_t;

  cmd_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  bit rnd_ready = 0;

  bit   prev_stall = 0;
  bit   prev_done = 0;
  cmd_t prev_cmd;

  frame_line_cmd_gen dut (
    .clk       (clk),
    .resetn    (resetn),
    .sof       (sof),
    .frame_addr(frame_addr),
    .img_width (img_width),
    .img_height(img_height),
    .stride    (stride),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_bytes (cmd_bytes),
    .cmd_last  (cmd_last),
    .busy      (busy),
    .frame_done(frame_done),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic sof_pulse();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic expect_frame(logic [31:0] addr, int w, int h,
                              logic [31:0] strd);
    for (int i = 0; i < h; i++) begin
      cmd_t c;
      c.a = addr + 32'(i) * strd;
      c.b = 16'(w * 4);
      c.l = (i == h - 1);
      exp_q.push_back(c);
    end
  endtask

  task automatic wait_done(int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    check("done_timeout", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_valid"}, 64'(cmd_valid), 64'd0);
    check({tag, "_addr"}, 64'(cmd_addr), 64'd0);
    check({tag, "_bytes"}, 64'(cmd_bytes), 64'd0);
    check({tag, "_last"}, 64'(cmd_last), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(frame_done), 64'd0);
    check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  always @(negedge clk) begin
    cmd_t got;
    got = '{a: cmd_addr, b: cmd_bytes, l: cmd_last};
    if (!resetn) begin
      prev_stall = 0;
      prev_done  = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(cmd_valid), 64'd1);
        check("stall_hold", 64'(got), 64'(prev_cmd));
      end
      if (cmd_valid && cmd_ready) begin
        check("cmd_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          cmd_t e;
          e = exp_q.pop_front();
          check("cmd", 64'(got), 64'(e));
        end
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_cmd   = got;
      if (frame_done) begin
        done_cnt++;
        check("done_width", 64'(prev_done), 64'd0);
        check("done_vs_valid", 64'(cmd_valid), 64'd0);
      end
      prev_done = frame_done;
    end
  end

  initial begin
    int d0;
    resetn     = 1'b0;
    sof        = 1'b0;
    cmd_ready  = 1'b0;
    frame_addr = 32'h3FF0_0000;
    img_width  = 12'd5;
    img_height = 12'd3;
    stride     = 32'h1000;
    repeat (3) tick();
    check_reset_outs("reset");
    resetn = 1'b1;
    tick();

    // basic frame and latency
    cmd_ready = 1'b1;
    d0 = done_cnt;
    expect_frame(32'h3FF0_0000, 5, 3, 32'h1000);
    sof_pulse();
    check("lat_c1", 64'(cmd_valid), 64'd0);
    tick();
    check("lat_c2", 64'(cmd_valid), 64'd0);
    tick();
    check("lat_c3", 64'(cmd_valid), 64'd1);
    check("first_addr", 64'(cmd_addr), 64'h3FF0_0000);
    check("first_busy", 64'(busy), 64'd1);
    wait_done(d0 + 1);
    repeat (3) tick();
    check("basic_q", 64'(exp_q.size()), 64'd0);
    check("basic_done", 64'(done_cnt), 64'(d0 + 1));

    // backpressure
    rnd_ready = 1;
    d0 = done_cnt;
    expect_frame(32'h3FF0_0000, 5, 3, 32'h1000);
    sof_pulse();
    wait_done(d0 + 1);
    rnd_ready = 0;
    cmd_ready = 1'b1;
    repeat (2) tick();
    check("bp_q", 64'(exp_q.size()), 64'd0);

    // pending and drop
    img_height = 12'd40;
    d0 = done_cnt;
    expect_frame(32'h3FF0_0000, 5, 40, 32'h1000);
    expect_frame(32'h3FF2_0000, 5, 40, 32'h1000);
    frame_addr = 32'h3FF0_0000;
    sof_pulse();
    repeat (9) tick();
    frame_addr = 32'h3FF1_0000;
    sof_pulse();
    repeat (9) tick();
    frame_addr = 32'h3FF2_0000;
    sof_pulse();
    wait_done(d0 + 2);
    repeat (3) tick();
    check("drop_cnt", 64'(drop_cnt), 64'd1);
    check("drop_q", 64'(exp_q.size()), 64'd0);
    check("drop_done", 64'(done_cnt), 64'(d0 + 2));

    // degenerate geometry
    img_height = 12'd0;
    d0 = done_cnt;
    sof_pulse();
    repeat (8) begin
      tick();
      check("deg_busy", 64'(busy), 64'd0);
      check("deg_valid", 64'(cmd_valid), 64'd0);
    end
    check("deg_done", 64'(done_cnt), 64'(d0 + 1));

    // wrap-around
    img_height = 12'd2;
    frame_addr = 32'hFFFF_F000;
    d0 = done_cnt;
    expect_frame(32'hFFFF_F000, 5, 2, 32'h1000);
    sof_pulse();
    wait_done(d0 + 1);
    repeat (2) tick();
    check("wrap_q", 64'(exp_q.size()), 64'd0);

    // reset mid-frame, with a pending frame queued
    img_height = 12'd6;
    frame_addr = 32'h2000_0000;
    d0 = done_cnt;
    expect_frame(32'h2000_0000, 5, 6, 32'h1000);
    sof_pulse();
    tick();
    tick();
    check("rst_valid_pre", 64'(cmd_valid), 64'd1);
    frame_addr = 32'h3000_0000;
    sof_pulse();
    tick();
    check("rst_two_hs", 64'(exp_q.size()), 64'd4);
    resetn    = 1'b0;
    cmd_ready = 1'b0;
    tick();
    check_reset_outs("midrst");
    exp_q.delete();
    resetn    = 1'b1;
    cmd_ready = 1'b1;
    repeat (6) begin
      tick();
      check("no_pend", 64'(cmd_valid), 64'd0);
    end
    check("rst_no_done", 64'(done_cnt), 64'(d0));

    frame_addr = 32'h2000_0000;
    expect_frame(32'h2000_0000, 5, 6, 32'h1000);
    sof_pulse();
    wait_done(d0 + 1);
    repeat (2) tick();
    check("restart_q", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
